ram_access_arbiter: RTL and testbench

- Sequences and shares the single-port program/data RAM between two requesters.
- Port A is the CPU memory stage. Port B is the debug/program-loader port.
- Converts a simple req/ack transaction into the RAM's two-phase protocol: registered address latch first, then write strobe or read sample with output enable.
- Sits between the requesters and the RAM; it is the only driver of the RAM's control pins.

---
 rtl/ram_access_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_access_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Two-port arbiter for the single-port program/data RAM: grants one requester,
// then runs the RAM's address-latch phase followed by a write or read phase.
module ram_access_arbiter #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_a_req,
    input  logic                  i_a_we,
    input  logic                  i_a_sel,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    output logic                  o_a_ack,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_req,
    input  logic                  i_b_we,
    input  logic                  i_b_sel,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    output logic                  o_b_ack,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic                  o_ram_addressEn,
    output logic [DATA_WIDTH-1:0] o_ram_writeData,
    output logic                  o_ram_writeEn,
    output logic                  o_ram_readDataSelect,
    output logic                  o_ram_outEnable,
    input  logic [DATA_WIDTH-1:0] i_ram_readData,
    output logic                  o_busy,
    output logic                  o_grant_b
);

    // Handshake: a requester raises req with stable fields and holds it until
    // the one-cycle ack; fields are sampled only at grant, in IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_XFER = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_owner_b;
    logic                  r_last_b;
    logic                  r_we;
    logic                  r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;
    logic                  w_any_req;
    logic                  w_pick_b;
    logic                  w_grant;

    always_comb begin
        w_any_req = i_a_req | i_b_req;
        w_pick_b  = i_b_req;
        if (i_a_req && i_b_req) begin
            w_pick_b = (ROUND_ROBIN != 0) ? ~r_last_b : 1'b1;
        end
        w_grant = (r_state == S_IDLE) && w_any_req;
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ADDR;
            S_ADDR:  w_next_state = S_XFER;
            S_XFER:  w_next_state = S_ACK;
            S_ACK:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Pointer resets to "B went last" so A wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_owner_b <= 1'b0;
            r_last_b  <= 1'b1;
            r_we      <= 1'b0;
            r_sel     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner_b <= w_pick_b;
                r_last_b  <= w_pick_b;
                r_we      <= w_pick_b ? i_b_we  : i_a_we;
                r_sel     <= w_pick_b ? i_b_sel : i_a_sel;
                r_addr    <= w_pick_b ? i_b_addr : i_a_addr;
                // Write data only moves on writes so the bus holds the last stored value.
                if (w_pick_b ? i_b_we : i_a_we) begin
                    r_wdata <= w_pick_b ? i_b_wdata : i_a_wdata;
                end
            end
            if ((r_state == S_XFER) && !r_we) begin
                if (r_owner_b) r_b_rdata <= i_ram_readData;
                else           r_a_rdata <= i_ram_readData;
            end
        end
    end

    always_comb begin
        o_ram_address        = r_addr;
        o_ram_writeData      = r_wdata;
        o_ram_readDataSelect = r_sel;
        o_ram_addressEn      = 1'b0;
        o_ram_writeEn        = 1'b0;
        o_ram_outEnable      = 1'b0;
        o_a_ack              = 1'b0;
        o_b_ack              = 1'b0;
        o_busy               = (r_state != S_IDLE);
        o_grant_b            = (r_state != S_IDLE) && r_owner_b;
        o_a_rdata            = r_a_rdata;
        o_b_rdata            = r_b_rdata;
        case (r_state)
            S_ADDR: o_ram_addressEn = 1'b1;
            S_XFER: begin
                o_ram_writeEn   = r_we;
                o_ram_outEnable = ~r_we;
            end
            S_ACK: begin
                o_a_ack = ~r_owner_b;
                o_b_ack = r_owner_b;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: RAM behavioural model, scoreboard fed
// by the stimulus, and a monitor that checks every ack against it.
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       nrst;
    logic       a_req, a_we, a_sel, b_req, b_we, b_sel;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ack, b_ack, ram_aen, ram_wen, ram_sel, ram_oe, busy, grant_b;
    logic [7:0] a_rdata, b_rdata, ram_address, ram_wdata, ram_rdata;
    logic       p_a_ack, p_b_ack, p_aen, p_wen, p_sel, p_oe, p_busy, p_grant_b;
    logic [7:0] p_a_rdata, p_b_rdata, p_address, p_wdata;

    logic [18:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ROUND_ROBIN(1)) u_dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_sel(a_sel), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_ack(a_ack), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_sel(b_sel), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_ack(b_ack), .o_b_rdata(b_rdata),
        .o_ram_address(ram_address), .o_ram_addressEn(ram_aen), .o_ram_writeData(ram_wdata),
        .o_ram_writeEn(ram_wen), .o_ram_readDataSelect(ram_sel), .o_ram_outEnable(ram_oe),
        .i_ram_readData(ram_rdata), .o_busy(busy), .o_grant_b(grant_b)
    );

    ram_access_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ROUND_ROBIN(0)) u_dut_fp (
        .i_clk(clk), .i_nrst(nrst),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_sel(a_sel), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_ack(p_a_ack), .o_a_rdata(p_a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_sel(b_sel), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_ack(p_b_ack), .o_b_rdata(p_b_rdata),
        .o_ram_address(p_address), .o_ram_addressEn(p_aen), .o_ram_writeData(p_wdata),
        .o_ram_writeEn(p_wen), .o_ram_readDataSelect(p_sel), .o_ram_outEnable(p_oe),
        .i_ram_readData(ram_rdata), .o_busy(p_busy), .o_grant_b(p_grant_b)
    );

    // RAM model: address latched on addressEn; unwritten cells read addr ^ 0x4A.
    logic [8:0] ram_lat;
    logic [7:0] mem [512];
    bit         written [512];

    always @(posedge clk) begin
        if (ram_aen) ram_lat <= {ram_sel, ram_address};
        if (ram_wen) begin
            mem[ram_lat]     <= ram_wdata;
            written[ram_lat] <= 1'b1;
        end
    end

    always_comb begin
        ram_rdata = written[ram_lat] ? mem[ram_lat] : (ram_lat[7:0] ^ 8'h4A);
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: records what the RAM saw, compares it with the scoreboard on each ack.
    logic       seen_we, seen_sel;
    logic [7:0] seen_addr, seen_data;
    logic [18:0] exp_item;

    always @(negedge clk) begin
        if (ram_aen) begin
            seen_addr = ram_address;
            seen_sel  = ram_sel;
        end
        if (ram_wen) begin
            seen_we   = 1'b1;
            seen_data = ram_wdata;
        end
        if (ram_oe) seen_we = 1'b0;
        if (a_ack || b_ack) begin
            if (a_ack && b_ack) begin
                check("double_ack", {a_ack, b_ack}, 2'b10);
            end else if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                check("sb_txn",
                      {b_ack, seen_we, seen_sel, seen_addr,
                       seen_we ? seen_data : (b_ack ? b_rdata : a_rdata)},
                      exp_item);
            end
        end
    end

    task automatic set_port(input bit pb, input bit we, input bit sel,
                            input logic [7:0] addr, input logic [7:0] wd, input bit req);
        if (pb) begin
            b_we = we; b_sel = sel; b_addr = addr; b_wdata = wd; b_req = req;
        end else begin
            a_we = we; a_sel = sel; a_addr = addr; a_wdata = wd; a_req = req;
        end
    endtask

    // Called just after a rising edge with the FSM idle; checks each phase.
    task automatic run_txn(input bit pb, input bit we, input bit sel, input logic [7:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_d, input bit mod_addr);
        exp_q.push_back({pb, we, sel, addr, exp_d});
        set_port(pb, we, sel, addr, wd, 1'b1);
        @(negedge clk);
        check("c0_idle", {busy, ram_aen, ram_wen, ram_oe}, 4'b0000);
        @(negedge clk);
        check("c1_addr", {ram_aen, ram_wen, ram_oe, ram_sel, ram_address}, {3'b100, sel, addr});
        check("c1_grant_b", {busy, grant_b}, {1'b1, pb});
        if (mod_addr) a_addr = 8'hFF;
        @(negedge clk);
        check("c2_xfer", {ram_aen, ram_wen, ram_oe, ram_sel, ram_address}, {1'b0, we, !we, sel, addr});
        if (we) check("c2_wdata", ram_wdata, wd);
        @(negedge clk);
        check("c3_ack", {a_ack, b_ack, ram_aen, ram_wen, ram_oe}, {!pb, pb, 3'b000});
        @(posedge clk);
        #1;
        set_port(pb, we, sel, addr, wd, 1'b0);
        @(negedge clk);
        check("idle_hold", {busy, grant_b, ram_aen, ram_wen, ram_oe, ram_address}, {5'b0, addr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        set_port(0, 1'b1, 1'b1, 8'h40, 8'h11, 1'b1);
        set_port(1, 1'b1, 1'b1, 8'h41, 8'h22, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("reset_out", {a_ack, b_ack, ram_aen, ram_wen, ram_oe, ram_sel, busy, grant_b,
                                a_rdata, b_rdata, ram_address, ram_wdata}, 40'd0);
        end
        // Both held: A, B, A, B on round robin; B every time on the fixed-priority copy.
        exp_q.push_back({1'b0, 1'b1, 1'b1, 8'h40, 8'h11});
        exp_q.push_back({1'b1, 1'b1, 1'b1, 8'h41, 8'h22});
        exp_q.push_back({1'b0, 1'b1, 1'b1, 8'h40, 8'h11});
        exp_q.push_back({1'b1, 1'b1, 1'b1, 8'h41, 8'h22});
        @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("rr_ack", {a_ack, b_ack},
                  (k % 4 == 3) ? (((k / 4) % 2 == 1) ? 2'b01 : 2'b10) : 2'b00);
            check("rr_grant_b", {busy, grant_b},
                  {k % 4 != 0, (k % 4 != 0) && ((k / 4) % 2 == 1)});
            check("fp_grant_b", {p_busy, p_grant_b, p_a_ack, p_b_ack},
                  {k % 4 != 0, k % 4 != 0, 1'b0, k % 4 == 3});
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk);
        #1;

        run_txn(0, 1'b1, 1'b1, 8'h3C, 8'hA5, 8'hA5, 1'b0);
        run_txn(1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0);
        check("b_rdata", b_rdata, 8'h5A);
        check("a_rdata_hold", a_rdata, 8'h00);
        run_txn(0, 1'b0, 1'b1, 8'h3C, 8'h00, 8'hA5, 1'b0);
        check("a_rdata_rt", a_rdata, 8'hA5);
        check("b_rdata_hold", b_rdata, 8'h5A);
        run_txn(0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h6A, 1'b1);
        check("a_rdata_latched", a_rdata, 8'h6A);

        // Reset dropped during the write phase aborts the transaction.
        set_port(0, 1'b1, 1'b0, 8'h55, 8'h33, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_xfer", {ram_wen, ram_wdata}, {1'b1, 8'h33});
        nrst = 1'b0;
        @(negedge clk);
        check("abort_clear", {ram_aen, ram_wen, ram_oe, busy, a_ack, b_ack, a_rdata, b_rdata},
              {6'b0, 16'h0000});
        @(posedge clk);
        #1;
        nrst  = 1'b1;
        a_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_ack", {a_ack, b_ack, busy}, 3'b000);
        end
        @(posedge clk);
        #1;
        run_txn(0, 1'b1, 1'b0, 8'h55, 8'h33, 8'h33, 1'b0);
        run_txn(0, 1'b0, 1'b0, 8'h55, 8'h00, 8'h33, 1'b0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
